// File: rtl/mc_open_bank_tracker.sv
// mc_open_bank_tracker: open-bank / open-row tracker for one SDRAM chip select.
// Build option MC_OBCT_TRACK_EN:
//   defined   -> full tracker (per-bank open bit plus stored row, one bank slice per bank)
//   undefined -> dummy tracker for an unpopulated chip select (no flops, outputs tied low)
// All outputs are combinational from current state and current inputs.

`ifdef MC_OBCT_TRACK_EN
// One bank slice: the open flag and the row last activated in this bank.
module mc_obt_bank #(
  parameter int ROW_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             bank_set,
  input  logic             bank_clr,
  input  logic             bank_clr_all,
  input  logic [ROW_W-1:0] row_adr,
  output logic             open,
  output logic [ROW_W-1:0] row
);
  // Open flag: an activate to this bank wins over any precharge in the same cycle.
  always_ff @(posedge clk or negedge rst)
    if (!rst)                 open <= 1'b0;
    else if (bank_set & sel)  open <= 1'b1;
    else if (bank_clr & sel)  open <= 1'b0;
    else if (bank_clr_all)    open <= 1'b0;

  // Row latch: loaded on activate only; precharge leaves the stale row in place.
  always_ff @(posedge clk or negedge rst)
    if (!rst)                 row <= '0;
    else if (bank_set & sel)  row <= row_adr;
endmodule
`endif

module mc_open_bank_tracker #(
  parameter int ROW_W  = 13,
  parameter int BANK_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROW_W-1:0]  row_adr,
  input  logic [BANK_W-1:0] bank_adr,
  input  logic              bank_set,
  input  logic              bank_clr,
  input  logic              bank_clr_all,
  output logic              bank_open,
  output logic              any_bank_open,
  output logic              row_same
);
  localparam int NBANK = 2**BANK_W;

`ifdef MC_OBCT_TRACK_EN
  logic [NBANK-1:0]            open_v;
  logic [NBANK-1:0][ROW_W-1:0] row_v;

  // One slice per bank; each slice decodes its own select from bank_adr.
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    mc_obt_bank #(.ROW_W(ROW_W)) u_bank (
      .clk          (clk),
      .rst          (rst),
      .sel          (bank_adr == BANK_W'(b)),
      .bank_set     (bank_set),
      .bank_clr     (bank_clr),
      .bank_clr_all (bank_clr_all),
      .row_adr      (row_adr),
      .open         (open_v[b]),
      .row          (row_v[b])
    );
  end

  // Addressed-bank lookup; row compare is full width and ignores the open bit.
  always_comb begin
    bank_open     = open_v[bank_adr];
    row_same      = (row_v[bank_adr] == row_adr);
    any_bank_open = |open_v;
  end
`else
  // Unpopulated chip select: nothing is ever open, nothing ever hits.
  logic unused_inputs;
  assign unused_inputs = ^{clk, rst, row_adr, bank_adr, bank_set, bank_clr, bank_clr_all};

  always_comb begin
    bank_open     = 1'b0;
    row_same      = 1'b0;
    any_bank_open = 1'b0;
  end
`endif
endmodule

// File: tb/tb_mc_open_bank_tracker.sv
// tb_mc_open_bank_tracker: directed + short random bench with an independent bank model.
// Expected outputs are pushed to a scoreboard when stimulus is driven and popped when
// the DUT output is sampled (1 time unit after drive, away from the clock edges).
module tb_mc_open_bank_tracker;
  localparam int ROW_W  = 13;
  localparam int BANK_W = 2;
  localparam int NBANK  = 4;
`ifdef MC_OBCT_TRACK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ROW_W-1:0]  row_adr = '0;
  logic [BANK_W-1:0] bank_adr = '0;
  logic              bank_set = 1'b0;
  logic              bank_clr = 1'b0;
  logic              bank_clr_all = 1'b0;
  logic              bank_open, any_bank_open, row_same;

  mc_open_bank_tracker #(.ROW_W(ROW_W), .BANK_W(BANK_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .row_adr       (row_adr),
    .bank_adr      (bank_adr),
    .bank_set      (bank_set),
    .bank_clr      (bank_clr),
    .bank_clr_all  (bank_clr_all),
    .bank_open     (bank_open),
    .any_bank_open (any_bank_open),
    .row_same      (row_same)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [NBANK-1:0] m_open;
  logic [ROW_W-1:0] m_row [NBANK];

  // Scoreboard: {bank_open, any_bank_open, row_same}
  logic [2:0] sb [$];
  int n_run  = 0;
  int n_fail = 0;

  task automatic model_reset();
    m_open = '0;
    for (int b = 0; b < NBANK; b++) m_row[b] = '0;
  endtask

  // Apply one clock edge worth of commands to the model.
  task automatic model_edge();
    logic [NBANK-1:0] nxt;
    nxt = m_open;
    for (int b = 0; b < NBANK; b++) begin
      if (bank_set && bank_adr == b) begin
        nxt[b]  = 1'b1;
        m_row[b] = row_adr;
      end else if (bank_clr && bank_adr == b) nxt[b] = 1'b0;
      else if (bank_clr_all)                  nxt[b] = 1'b0;
    end
    m_open = nxt;
  endtask

  task automatic push_exp();
    logic [2:0] e;
    if (EN) e = {m_open[bank_adr], |m_open, m_row[bank_adr] == row_adr};
    else    e = 3'b000;
    sb.push_back(e);
  endtask

  task automatic sample(input string tag);
    logic [2:0] e;
    logic [2:0] o;
    if (sb.size() == 0) begin
      n_run++; n_fail++;
      $error("FAIL %s scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    o = {bank_open, any_bank_open, row_same};
    n_run++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s obs{open,any,same}=%b exp=%b", tag, o, e);
    end
  endtask

  // Drive address only (no clock), check combinational outputs.
  task automatic probe(input string tag, input int b, input int r);
    bank_adr = BANK_W'(b); row_adr = ROW_W'(r);
    bank_set = 0; bank_clr = 0; bank_clr_all = 0;
    push_exp(); #1; sample(tag);
  endtask

  // One clocked step: drive at negedge, check pre-edge outputs, then commit at posedge.
  task automatic step(input string tag, input int b, input int r,
                      input bit s, input bit c, input bit ca);
    @(negedge clk);
    bank_adr = BANK_W'(b); row_adr = ROW_W'(r);
    bank_set = s; bank_clr = c; bank_clr_all = ca;
    push_exp(); #1; sample(tag);
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle_check(input string tag, input int b, input int r);
    @(negedge clk);
    probe(tag, b, r);
  endtask

  initial begin
    model_reset();
    // 1: reset state, all banks, row 0 compares equal to reset row
    #2;
    for (int b = 0; b < NBANK; b++) probe($sformatf("rst_b%0d", b), b, 0);
    probe("rst_row_ne", 1, 5);
    @(negedge clk); rst = 1'b1;
    for (int b = 0; b < NBANK; b++) idle_check($sformatf("post_rst_b%0d", b), b, 0);

    // 2: activate bank 2 row 0x1A5
    step("set_b2", 2, 'h1A5, 1, 0, 0);
    idle_check("b2_hit", 2, 'h1A5);
    idle_check("b2_miss", 2, 'h1A4);
    idle_check("b1_closed", 1, 'h1A5);
    idle_check("b2_msb_miss", 2, 'h11A5);

    // 3: banks 0 and 3 open, precharge bank 0
    step("set_b0", 0, 'h010, 1, 0, 0);
    step("set_b3", 3, 'h033, 1, 0, 0);
    step("clr_b0", 0, 'h010, 0, 1, 0);
    idle_check("b0_closed", 0, 'h010);
    idle_check("b3_open", 3, 'h033);
    step("clr_b2", 2, 0, 0, 1, 0);
    step("clr_b3", 3, 0, 0, 1, 0);
    idle_check("none_open", 3, 'h033);
    idle_check("stale_row", 2, 'h1A5);

    // 4: all open, precharge-all with activate on bank 1
    for (int b = 0; b < NBANK; b++) step($sformatf("open_all_b%0d", b), b, 'h100 + b, 1, 0, 0);
    idle_check("all_open", 2, 'h102);
    step("clrall_set_b1", 1, 'h7, 1, 0, 1);
    idle_check("b1_after_clrall", 1, 'h7);
    idle_check("b0_after_clrall", 0, 'h100);
    idle_check("b3_after_clrall", 3, 'h103);

    // 5: set and clr together on bank 2
    step("set_clr_b2", 2, 'h0AB, 1, 1, 0);
    idle_check("b2_setclr", 2, 'h0AB);
    idle_check("b2_setclr_old", 2, 'h102);

    // Async reset mid-operation closes everything immediately
    @(negedge clk);
    rst = 1'b0; #1; model_reset();
    probe("midrst_b2", 2, 'h0AB);
    probe("midrst_b1_row0", 1, 0);
    @(negedge clk); rst = 1'b1;

    // Short random run against the model
    for (int i = 0; i < 60; i++)
      step($sformatf("rnd%0d", i), $urandom_range(0, NBANK-1), $urandom_range(0, 15),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));

    if (sb.size() != 0) begin
      n_run++; n_fail++;
      $error("FAIL sb_drain leftover=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  // Time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
